// File: rtl/sram_req_pkg.sv
// Shared types and helpers for the SRAM request controller.
package sram_req_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_RESP   = 3'd4,
        S_CLR    = 3'd5
    } state_t;

    localparam logic [3:0] STRB_FULL  = 4'hF;
    localparam int         RD_LAT_MIN = 1;
    localparam int         RD_LAT_MAX = 2;

    // Byte i of the result comes from new_word when strb[i] is set, else from old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake bundle between a core LSU/fetch unit (master)
// and the SRAM request controller (slave).
interface sram_req_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wstrb, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wstrb, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_rmw_merge.sv
// Combinational byte merge used for the write half of a read-modify-write.
module sram_rmw_merge
    import sram_req_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  strb,
    output logic [31:0] merged
);
    assign merged = merge_bytes(old_word, new_word, strb);
endmodule

// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for one word-wide SRAM port. One request in
// flight; sub-word stores become read-modify-write. Optional build macro
// SRAM_INIT_CLEAR_EN adds a post-reset sweep that zeroes the whole array.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a request; req_ready driven high
// S_RD     | read issued, waiting RD_LAT cycles, then capture sram_dout
// S_RMW_RD | partial-store read issued, waiting, then issue merged write
// S_RMW_WR | write issued (or skipped for empty strobe); raise response
// S_RESP   | response held until resp_ready
// S_CLR    | post-reset zero sweep (SRAM_INIT_CLEAR_EN builds only)
module sram_req_ctrl
    import sram_req_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_req_ctrl_if.slave     req,
    output logic               sram_we,
    output logic               sram_rd,
    output logic [31:0]        sram_addr,
    output logic [31:0]        sram_din,
    input  logic [31:0]        sram_dout,
    output logic               init_busy
);

    localparam int LAT_EFF = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                             (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;

`ifdef SRAM_INIT_CLEAR_EN
    localparam state_t RST_STATE = S_CLR;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t      state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ready_q, ready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] merged;
    logic [31:0] word_addr;
    logic        unused_addr_bits;

    // Upper address bits and the byte offset are intentionally dropped: out-of-range addresses alias.
    assign word_addr        = {{(32-ADDR_W){1'b0}}, req.req_addr[ADDR_W+1:2]};
    assign unused_addr_bits = ^{req.req_addr[31:ADDR_W+2], req.req_addr[1:0]};

    sram_rmw_merge u_merge (
        .old_word (sram_dout),
        .new_word (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged)
    );

`ifdef SRAM_INIT_CLEAR_EN
    logic [ADDR_W:0] clr_q, clr_d;
    logic            busy_q, busy_d;
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        ready_d  = 1'b0;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        rd_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
`ifdef SRAM_INIT_CLEAR_EN
        clr_d    = clr_q;
        busy_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (req.req_valid && ready_q) begin
                    ready_d = 1'b0;
                    addr_d  = word_addr;
                    wdata_d = req.req_wdata;
                    wstrb_d = req.req_wstrb;
                    lat_d   = 2'(LAT_EFF);
                    if (!req.req_wr) begin
                        rd_d    = 1'b1;
                        state_d = S_RD;
                    end else if (req.req_wstrb == STRB_FULL) begin
                        we_d    = 1'b1;
                        din_d   = req.req_wdata;
                        state_d = S_RMW_WR;
                    end else if (req.req_wstrb == 4'h0) begin
                        state_d = S_RMW_WR;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                if (lat_q == 2'd0) begin
                    rdata_d  = sram_dout;
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_RMW_RD: begin
                if (lat_q == 2'd0) begin
                    we_d    = 1'b1;
                    din_d   = merged;
                    state_d = S_RMW_WR;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_RMW_WR: begin
                rvalid_d = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (req.resp_ready) begin
                    rvalid_d = 1'b0;
                    rdata_d  = 32'h0;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
`ifdef SRAM_INIT_CLEAR_EN
            S_CLR: begin
                if (clr_q[ADDR_W]) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    addr_d = {{(31-ADDR_W){1'b0}}, clr_q};
                    din_d  = 32'h0;
                    clr_d  = clr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            lat_q    <= 2'd0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= 32'h0;
            din_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

`ifdef SRAM_INIT_CLEAR_EN
    // Sweep counter and busy flag; the extra counter bit marks sweep completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            clr_q  <= clr_d;
            busy_q <= busy_d;
        end
    end
    assign init_busy = busy_q;
`else
    assign init_busy = 1'b0;
`endif

    assign req.req_ready  = ready_q;
    assign req.resp_valid = rvalid_q;
    assign req.resp_rdata = rdata_q;
    assign sram_we        = we_q;
    assign sram_rd        = rd_q;
    assign sram_addr      = addr_q;
    assign sram_din       = din_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl (ADDR_W=13, RD_LAT=1) with a behavioural SRAM.
module tb_sram_req_ctrl;

    localparam int ADDR_W = 13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sram_we, sram_rd, init_busy;
    logic [31:0] sram_addr, sram_din;
    logic [31:0] sram_dout = 32'h0;

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int rd_cnt = 0;
    logic overlap_seen = 1'b0;
    int we0, rd0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    sram_req_ctrl_if bus ();

    sram_req_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.slave),
        .sram_we   (sram_we),
        .sram_rd   (sram_rd),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM model plus access pulse counters.
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr[ADDR_W-1:0]] <= sram_din;
        if (sram_rd) sram_dout <= mem[sram_addr[ADDR_W-1:0]];
        if (sram_we) we_cnt <= we_cnt + 1;
        if (sram_rd) rd_cnt <= rd_cnt + 1;
        if (sram_we && sram_rd) overlap_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a request at a negedge with req_ready high; returns in cycle N+1.
    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata);
        chk("ready_before_issue", {31'b0, bus.req_ready}, 32'h1);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wstrb = strb;
        bus.req_wdata = wdata;
        step();
        bus.req_valid = 1'b0;
    endtask

    // Full-word write, followed through to req_ready returning.
    task automatic full_write(input logic [31:0] addr, input logic [31:0] wdata);
        issue(1'b1, addr, 4'hF, wdata);
        step();
        chk("wr_resp_valid", {31'b0, bus.resp_valid}, 32'h1);
        step();
    endtask

    // Read with resp_ready=1; checks data at N+3 and idles to N+4.
    task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, addr, 4'h0, 32'h0);
        step();
        step();
        chk({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'h1);
        chk(tag, bus.resp_rdata, exp);
        step();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wstrb  = 4'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;
        step();
        step();
        chk("rst_req_ready",  {31'b0, bus.req_ready},  32'h0);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_sram_we_rd", {30'b0, sram_we, sram_rd}, 32'h0);
        chk("rst_init_busy",  {31'b0, init_busy}, 32'h0);
        rst_n = 1'b1;
`ifdef SRAM_INIT_CLEAR_EN
        begin
            int n = 0;
            while (!bus.req_ready && n < 20000) begin
                step();
                n++;
            end
        end
        chk("clr_write_count", we_cnt, 32'(1 << ADDR_W));
`else
        step();
`endif
        chk("ready_after_rst", {31'b0, bus.req_ready}, 32'h1);

        // 1: full write then read
        issue(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        chk("t1_we",       {31'b0, sram_we}, 32'h1);
        chk("t1_rd",       {31'b0, sram_rd}, 32'h0);
        chk("t1_addr",     sram_addr, 32'h40);
        chk("t1_din",      sram_din, 32'hDEADBEEF);
        chk("t1_ready_lo", {31'b0, bus.req_ready}, 32'h0);
        step();
        chk("t1_wr_resp",  {31'b0, bus.resp_valid}, 32'h1);
        chk("t1_wr_rdata", bus.resp_rdata, 32'h0);
        step();
        chk("t1_resp_drop", {31'b0, bus.resp_valid}, 32'h0);
        issue(1'b0, 32'h100, 4'h0, 32'h0);
        chk("t1_rd_pulse", {31'b0, sram_rd}, 32'h1);
        chk("t1_rd_addr",  sram_addr, 32'h40);
        step();
        chk("t1_n2_valid", {31'b0, bus.resp_valid}, 32'h0);
        step();
        chk("t1_n3_valid", {31'b0, bus.resp_valid}, 32'h1);
        chk("t1_rdata",    bus.resp_rdata, 32'hDEADBEEF);
        step();

        // 2: partial-strobe read-modify-write
        full_write(32'h8, 32'h11223344);
        we0 = we_cnt;
        rd0 = rd_cnt;
        issue(1'b1, 32'h8, 4'b0010, 32'h0000AA00);
        chk("t2_rd_first", {30'b0, sram_we, sram_rd}, 32'h1);
        chk("t2_addr",     sram_addr, 32'h2);
        step();
        chk("t2_gap",      {30'b0, sram_we, sram_rd}, 32'h0);
        step();
        chk("t2_we",       {30'b0, sram_we, sram_rd}, 32'h2);
        chk("t2_merged",   sram_din, 32'h1122AA44);
        chk("t2_n3_valid", {31'b0, bus.resp_valid}, 32'h0);
        step();
        chk("t2_n4_valid", {31'b0, bus.resp_valid}, 32'h1);
        step();
        chk("t2_we_count", we_cnt - we0, 32'h1);
        chk("t2_rd_count", rd_cnt - rd0, 32'h1);
        read_expect("t2_readback", 32'h8, 32'h1122AA44);

        // 3: response held under back-pressure; simultaneous new request not taken
        bus.resp_ready = 1'b0;
        issue(1'b0, 32'h100, 4'h0, 32'h0);
        step();
        step();
        chk("t3_valid", {31'b0, bus.resp_valid}, 32'h1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h8;
        we0 = we_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid", {31'b0, bus.resp_valid}, 32'h1);
            chk("t3_hold_rdata", bus.resp_rdata, 32'hDEADBEEF);
            chk("t3_hold_ready", {31'b0, bus.req_ready}, 32'h0);
            chk("t3_hold_sram",  {30'b0, sram_we, sram_rd}, 32'h0);
        end
        bus.resp_ready = 1'b1;
        step();
        chk("t3_released",  {31'b0, bus.resp_valid}, 32'h0);
        chk("t3_ready_up",  {31'b0, bus.req_ready}, 32'h1);
        chk("t3_no_accept", {31'b0, sram_rd}, 32'h0);
        chk("t3_quiet",     (we_cnt - we0) + (rd_cnt - rd0), 32'h0);
        step();
        bus.req_valid = 1'b0;
        chk("t3_late_rd",   {31'b0, sram_rd}, 32'h1);
        chk("t3_late_addr", sram_addr, 32'h2);
        step();
        step();
        chk("t3_late_rdata", bus.resp_rdata, 32'h1122AA44);
        step();

        // 4: empty strobe touches nothing
        full_write(32'h20, 32'h5A5A5A5A);
        we0 = we_cnt;
        rd0 = rd_cnt;
        issue(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
        chk("t4_no_access", {30'b0, sram_we, sram_rd}, 32'h0);
        step();
        chk("t4_n2_valid", {31'b0, bus.resp_valid}, 32'h1);
        chk("t4_rdata",    bus.resp_rdata, 32'h0);
        step();
        chk("t4_counts",   (we_cnt - we0) + (rd_cnt - rd0), 32'h0);
        read_expect("t4_unchanged", 32'h20, 32'h5A5A5A5A);

        // 5: address aliasing, then reset in the middle of an RMW read
        issue(1'b1, 32'h0004_0004, 4'hF, 32'hCAFEF00D);
        chk("t5_alias_addr", sram_addr, 32'h1);
        step();
        step();
        read_expect("t5_alias_read", 32'h4, 32'hCAFEF00D);
        we0 = we_cnt;
        issue(1'b1, 32'h4, 4'b0001, 32'h000000FF);
        chk("t5_rmw_rd", {31'b0, sram_rd}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sram",  {30'b0, sram_we, sram_rd}, 32'h0);
        chk("t5_rst_ready", {31'b0, bus.req_ready}, 32'h0);
        chk("t5_rst_valid", {31'b0, bus.resp_valid}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t5_ready_back", {31'b0, bus.req_ready}, 32'h1);
        chk("t5_no_write",   we_cnt - we0, 32'h0);
        read_expect("t5_mem_kept", 32'h4, 32'hCAFEF00D);

        chk("we_rd_exclusive", {31'b0, overlap_seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=stalled expected=finished");
        $fatal(1, "timeout");
    end

endmodule
